up_counter: RTL and testbench
=============================

# up_counter

Free-running synchronous binary up-counter, module name `up_counter`, with a parameterised output width. It increments once per rising clock edge and wraps modulo 2^Size. It serves as the reference DUT for the co-simulation flow, where the software side drives `reset` and samples `count` shortly after each rising edge. It has no enable, load or direction control; the count is purely a function of clock edges since the last reset.

## Interface
Parameters:
- Size, default 5, width of `count` in bits; legal range 1..32.

Ports:
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset: `reset` = 0 at a rising edge of `clock` clears the counter.
- count  output  Size  current count value, driven directly from a register with no combinational path from inputs.

## Operation
- State is one Size-bit register, `count`.
- At each rising edge of `clock`:
  - if `reset` = 0, `count` <= 0;
  - otherwise `count` <= (`count` + 1) mod 2^Size.
- Reset has priority over counting at every edge; no other input exists.
- Wrap-around: from all-ones (31 for Size=5), the next non-reset edge yields 0. No terminal-count flag, no saturation.
- Reset mid-operation: any count value is cleared to 0 at the first edge where `reset` = 0. The count stays 0 for as long as reset is held.
- Reset release: the first edge with `reset` = 1 produces 1. After the release, N non-reset edges yield `count` = N mod 2^Size.
- Power-up: `count` is undefined (X in simulation) until the first reset edge. The block must not rely on an initial value; the environment applies reset before checking.
- Arithmetic is unsigned. The carry out of the MSB is discarded.

## Timing
- Latency: 1 clock. `count` reflects the reset or increment decision made at the preceding rising edge.
- `count` must be stable within the same time step as the edge, using non-blocking register update. The environment samples 1 time unit after each rising edge with a 10-unit clock period.
- `reset` is sampled only at rising edges. Reset pulses shorter than the setup window before an edge have no effect.
- No asynchronous paths. No multicycle or false paths.

## Structure
- Single flat module, `up_counter`: one always-block register plus an incrementer.
- No shared package is required; Size is the only constant and is a module parameter.
- No sub-modules.

## Test plan
- Reset hold: drive `reset` = 0 for 3 edges -> `count` = 0 after each edge, including from an X power-up state.
- Count-up: release reset (`reset` = 1) and run 10 edges -> `count` reads 1, 2, …, 10 at successive samples.
- Wrap-around (Size=5): run 31 edges after reset, then 1 more -> `count` = 31, then 0, then 1 on the following edge.
- Mid-count reset: at `count` = 17, assert `reset` = 0 for one edge -> `count` = 0. Release -> next edge gives 1.
- Parameter override: instantiate with Size = 3 and run 9 edges after reset -> sequence 1..7, 0, 1. `count` width is 3 bits.
- Reset held across wrap boundary: assert reset while `count` = 31 -> `count` = 0 (not 1). It stays 0 while reset is held.

Source files
------------

// File: rtl/up_counter_pkg.sv
// Shared constants for the up_counter reference block.
// Holds the default and legal range of the count width.
package up_counter_pkg;

    localparam int DEFAULT_SIZE = 5;
    localparam int MIN_SIZE     = 1;
    localparam int MAX_SIZE     = 32;

endpackage : up_counter_pkg

// File: rtl/up_counter.sv
// Free-running binary up-counter that wraps modulo 2^Size.
// Synchronous active-low reset clears it; count comes straight from the register.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int Size = DEFAULT_SIZE
) (
    input  logic            clock,
    input  logic            reset,
    output logic [Size-1:0] count
);

    logic [Size-1:0] r_count;
    logic [Size-1:0] w_next;

    // Carry out of the MSB is dropped, which gives the wrap from all-ones to zero.
    assign w_next = r_count + Size'(1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule : up_counter

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter at Size=5 and Size=3.
// The reference counts non-reset edges since the last reset and reduces modulo 2^Size.
module tb_up_counter;

    logic       clock;
    logic       reset;
    logic [4:0] count5;
    logic [2:0] count3;

    int  checks;
    int  errors;
    int  edgesSinceReset;
    bit  modelValid;

    up_counter #(.Size(5)) dut5 (
        .clock (clock),
        .reset (reset),
        .count (count5)
    );

    up_counter #(.Size(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .count (count3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compares both instances against the edge-count reference.
    task automatic checkOutput(input string tag);
        logic [4:0] exp5;
        logic [2:0] exp3;
        exp5 = 5'(edgesSinceReset % 32);
        exp3 = 3'(edgesSinceReset % 8);
        checks++;
        assert (count5 === exp5) else begin
            errors++;
            $error("FAIL %s size5 count=%0d expected=%0d", tag, count5, exp5);
        end
        checks++;
        assert (count3 === exp3) else begin
            errors++;
            $error("FAIL %s size3 count=%0d expected=%0d", tag, count3, exp3);
        end
    endtask

    // Drives reset for one edge, samples 1 unit after it and advances the reference.
    task automatic applyStimulus(input logic rstLevel, input string tag);
        reset = rstLevel;
        @(posedge clock);
        #1;
        if (!rstLevel) begin
            edgesSinceReset = 0;
            modelValid      = 1'b1;
        end else begin
            edgesSinceReset++;
        end
        if (modelValid) checkOutput(tag);
    endtask

    // Checks a directed literal value on the Size=5 instance.
    task automatic checkLiteral5(input string tag, input logic [4:0] want);
        checks++;
        assert (count5 === want) else begin
            errors++;
            $error("FAIL %s size5 count=%0d expected=%0d", tag, count5, want);
        end
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        edgesSinceReset = 0;
        modelValid      = 1'b0;
        reset           = 1'b1;
        #2;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, "reset_hold");
        checkLiteral5("reset_hold_zero", 5'd0);

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, "count_up");
        checkLiteral5("count_up_ten", 5'd10);

        applyStimulus(1'b0, "wrap_reset");
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, "wrap_run");
        checkLiteral5("wrap_all_ones", 5'd31);
        applyStimulus(1'b1, "wrap_zero");
        checkLiteral5("wrap_zero_lit", 5'd0);
        applyStimulus(1'b1, "wrap_one");
        checkLiteral5("wrap_one_lit", 5'd1);

        applyStimulus(1'b0, "mid_reset_pre");
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, "mid_run");
        checkLiteral5("mid_at_17", 5'd17);
        applyStimulus(1'b0, "mid_reset");
        checkLiteral5("mid_cleared", 5'd0);
        applyStimulus(1'b1, "mid_release");
        checkLiteral5("mid_release_one", 5'd1);

        applyStimulus(1'b0, "held_pre");
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, "held_run");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, "held_at_wrap");
        checkLiteral5("held_zero", 5'd0);

        for (int i = 0; i < 9; i++) applyStimulus(1'b1, "size3_seq");

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_up_counter
